// File: rtl/noc_link_input_fifo.sv
// noc_link_input_fifo
//   Router input-port buffer fed by the link pipeline register. Flits are
//   queued in a DEPTH-entry FIFO. The head flit is shown first-word-fall-through.
//   Each dequeued flit returns one credit pulse upstream.
//
// Ports
//   clk           rising-edge clock
//   rst           asynchronous active-low reset
//   write_en_i    flit valid from link register
//   write_data_i  flit from link register
//   full_o        FIFO holds DEPTH entries
//   read_en_i     router consumes head flit this cycle
//   valid_o       head flit present
//   read_data_o   head flit (0 when empty)
//   count_o       occupancy 0..DEPTH
//   credit_o      one-cycle pulse the cycle after each dequeue
//   overflow_o    sticky: a write arrived while full
module noc_link_input_fifo #(
  parameter  int WIDTH  = 16,
  parameter  int DEPTH  = 4,
  localparam int ADDR_W = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              write_en_i,
  input  logic [WIDTH-1:0]  write_data_i,
  output logic              full_o,
  input  logic              read_en_i,
  output logic              valid_o,
  output logic [WIDTH-1:0]  read_data_o,
  output logic [ADDR_W:0]   count_o,
  output logic              credit_o,
  output logic              overflow_o
);

  localparam int PTR_W = ADDR_W + 1;

  logic [WIDTH-1:0] mem_q [DEPTH];

  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [ADDR_W:0]  count_q,  count_d;
  logic             credit_q, credit_d;
  logic             ovf_q,    ovf_d;

  logic empty, full, wr_acc, rd_acc;

  // Extra wrap bit separates full (wrap bits differ) from empty (all equal).
  assign empty = (wr_ptr_q == rd_ptr_q);
  assign full  = (wr_ptr_q[ADDR_W-1:0] == rd_ptr_q[ADDR_W-1:0]) &&
                 (wr_ptr_q[ADDR_W] != rd_ptr_q[ADDR_W]);

  // Both checks use pre-edge state: a same-cycle read never makes room for a
  // write to a full FIFO, and a same-cycle write never feeds a read of an
  // empty one (no bypass).
  assign wr_acc = write_en_i && !full;
  assign rd_acc = read_en_i  && !empty;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    credit_d = rd_acc;
    ovf_d    = ovf_q | (write_en_i & full);
    if (wr_acc) wr_ptr_d = wr_ptr_q + PTR_W'(1);
    if (rd_acc) rd_ptr_d = rd_ptr_q + PTR_W'(1);
    case ({wr_acc, rd_acc})
      2'b10:   count_d = count_q + PTR_W'(1);
      2'b01:   count_d = count_q - PTR_W'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      credit_q <= 1'b0;
      ovf_q    <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      credit_q <= credit_d;
      ovf_q    <= ovf_d;
    end
  end

  // Storage is not reset. Stale entries are never visible because the
  // pointers are cleared.
  always_ff @(posedge clk) begin
    if (wr_acc) mem_q[wr_ptr_q[ADDR_W-1:0]] <= write_data_i;
  end

  assign valid_o     = !empty;
  assign read_data_o = empty ? '0 : mem_q[rd_ptr_q[ADDR_W-1:0]];
  assign full_o      = full;
  assign count_o     = count_q;
  assign credit_o    = credit_q;
  assign overflow_o  = ovf_q;

endmodule

// File: tb/tb_noc_link_input_fifo.sv
module tb_noc_link_input_fifo;

  localparam int WIDTH = 16;
  localparam int DEPTH = 4;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              write_en_i = 1'b0;
  logic [WIDTH-1:0]  write_data_i = '0;
  logic              read_en_i = 1'b0;
  logic              full_o, valid_o, credit_o, overflow_o;
  logic [WIDTH-1:0]  read_data_o;
  logic [2:0]        count_o;

  int vectors = 0;
  int miscompares = 0;
  int credit_cnt = 0;
  logic exp_credit = 1'b0;
  logic [WIDTH-1:0] sb[$];

  noc_link_input_fifo #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst),
    .write_en_i(write_en_i), .write_data_i(write_data_i), .full_o(full_o),
    .read_en_i(read_en_i), .valid_o(valid_o), .read_data_o(read_data_o),
    .count_o(count_o), .credit_o(credit_o), .overflow_o(overflow_o)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: pops the scoreboard on every dequeue and checks the credit pulse
  // one cycle after each dequeue.
  always @(negedge clk) begin
    if (!rst) begin
      exp_credit = 1'b0;
    end else begin
      chk("credit", credit_o, exp_credit);
      if (credit_o) credit_cnt++;
      if (valid_o && read_en_i) begin
        if (sb.size() == 0) chk("unexpected_pop", 1, 0);
        else chk("head_data", read_data_o, sb.pop_front());
      end
      exp_credit = valid_o && read_en_i;
    end
  end

  task automatic cyc(input logic we, input logic [WIDTH-1:0] wd, input logic re);
    write_en_i   = we;
    write_data_i = wd;
    read_en_i    = re;
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    cyc(1'b0, '0, 1'b0);
  endtask

  initial begin
    // Reset and idle
    #2 rst = 1'b0;
    #1;
    chk("rst_valid", valid_o, 0);
    chk("rst_full", full_o, 0);
    chk("rst_count", count_o, 0);
    chk("rst_credit", credit_o, 0);
    chk("rst_ovf", overflow_o, 0);
    chk("rst_data", read_data_o, 16'h0000);
    #4 rst = 1'b1;
    idle();
    chk("idle_valid", valid_o, 0);
    chk("idle_count", count_o, 0);

    // Fill then drain
    for (int i = 1; i <= 4; i++) begin
      sb.push_back(16'hA000 + 16'(i));
      cyc(1'b1, 16'hA000 + 16'(i), 1'b0);
    end
    chk("fill_full", full_o, 1);
    chk("fill_count", count_o, 4);
    chk("fill_head", read_data_o, 16'hA001);
    for (int i = 0; i < 4; i++) cyc(1'b0, '0, 1'b1);
    idle();
    chk("drain_count", count_o, 0);
    chk("drain_valid", valid_o, 0);
    chk("drain_data", read_data_o, 16'h0000);

    // Overflow: write while full is dropped even with a same-cycle read
    for (int i = 1; i <= 4; i++) begin
      sb.push_back(16'hA000 + 16'(i));
      cyc(1'b1, 16'hA000 + 16'(i), 1'b0);
    end
    cyc(1'b1, 16'hBEEF, 1'b1);
    chk("ovf_set", overflow_o, 1);
    chk("ovf_count", count_o, 3);
    chk("ovf_full", full_o, 0);
    for (int i = 0; i < 3; i++) cyc(1'b0, '0, 1'b1);
    idle();
    chk("ovf_sticky", overflow_o, 1);
    chk("ovf_empty", valid_o, 0);

    // Wrap-around with simultaneous read/write at occupancy 2
    sb.push_back(16'hD000); cyc(1'b1, 16'hD000, 1'b0);
    sb.push_back(16'hD001); cyc(1'b1, 16'hD001, 1'b0);
    credit_cnt = 0;
    for (int i = 0; i < 10; i++) begin
      sb.push_back(16'hC000 + 16'(i));
      cyc(1'b1, 16'hC000 + 16'(i), 1'b1);
      chk("wrap_count", count_o, 2);
    end
    idle();
    chk("wrap_credits", credit_cnt, 10);
    cyc(1'b0, '0, 1'b1);
    cyc(1'b0, '0, 1'b1);
    idle();
    chk("wrap_empty", count_o, 0);

    // No bypass on empty: write + read same cycle stores, read ignored
    sb.push_back(16'h1234);
    cyc(1'b1, 16'h1234, 1'b1);
    chk("nobyp_valid", valid_o, 1);
    chk("nobyp_data", read_data_o, 16'h1234);
    chk("nobyp_count", count_o, 1);
    chk("nobyp_credit", credit_o, 0);

    // Async reset with 3 queued and credit high
    sb.push_back(16'hE001); cyc(1'b1, 16'hE001, 1'b0);
    sb.push_back(16'hE002); cyc(1'b1, 16'hE002, 1'b0);
    sb.push_back(16'hE003); cyc(1'b1, 16'hE003, 1'b1);
    chk("pre_rst_count", count_o, 3);
    chk("pre_rst_credit", credit_o, 1);
    write_en_i = 1'b0; read_en_i = 1'b0;
    #1 rst = 1'b0;
    #1;
    sb.delete();
    chk("arst_valid", valid_o, 0);
    chk("arst_full", full_o, 0);
    chk("arst_count", count_o, 0);
    chk("arst_credit", credit_o, 0);
    chk("arst_ovf", overflow_o, 0);
    chk("arst_data", read_data_o, 16'h0000);
    #4 rst = 1'b1;
    sb.push_back(16'h5555);
    cyc(1'b1, 16'h5555, 1'b0);
    chk("post_rst_head", read_data_o, 16'h5555);
    chk("post_rst_count", count_o, 1);
    cyc(1'b0, '0, 1'b1);
    idle();
    idle();
    chk("sb_drained", sb.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
